// File: rtl/pim_instr_issue.sv
// pim_instr_issue: host instruction FIFO feeding the PIM instruction register,
// issuing one word at a time with a load strobe, then waiting for PIM_done.
module pim_instr_issue #(
  parameter int N = 38,
  parameter int DEPTH = 16,
  localparam int CW = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          host_wr,
  input  logic [N-1:0]  host_instr,
  input  logic          flush,
  input  logic          run,
  input  logic          PIM_done,
  output logic [N-1:0]  instr_out,
  output logic          PIM_load,
  output logic          busy,
  output logic          host_full,
  output logic [CW-1:0] fifo_count,
  output logic          err_ovf,
  output logic [15:0]   issued_cnt
);
  localparam int AW = $clog2(DEPTH);
  typedef enum logic {IDLE, EXEC} state_t;
  state_t state, state_nx;
  logic [N-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic issue, done_ok, wr_en, ovf;
  assign host_full = fifo_count == CW'(DEPTH);
  // done is ignored while the strobe is still high
  always_comb begin
    issue = state == IDLE && run && fifo_count != '0 && !flush;
    done_ok = state == EXEC && !PIM_load && PIM_done;
    wr_en = host_wr && !flush && (!host_full || issue);
    ovf = host_wr && !flush && host_full && !issue;
    state_nx = issue ? EXEC : done_ok ? IDLE : state;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= state_nx;
  always_ff @(posedge clk)
    if (wr_en) mem[wr_ptr] <= host_instr;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      fifo_count <= '0;
      err_ovf <= 1'b0;
      PIM_load <= 1'b0;
      busy <= 1'b0;
      instr_out <= '0;
      issued_cnt <= '0;
    end else begin
      if (flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        fifo_count <= '0;
      end else begin
        if (wr_en) wr_ptr <= wr_ptr + 1'b1;
        if (issue) rd_ptr <= rd_ptr + 1'b1;
        fifo_count <= fifo_count + CW'(wr_en) - CW'(issue);
      end
      if (ovf) err_ovf <= 1'b1;
      PIM_load <= issue;
      if (issue) begin
        instr_out <= mem[rd_ptr];
        issued_cnt <= issued_cnt + 16'd1;
        busy <= 1'b1;
      end else if (done_ok) busy <= 1'b0;
    end
endmodule

// File: tb/tb_pim_instr_issue.sv
// tb_pim_instr_issue: randomized and directed stimulus against a queue-based
// reference model; a monitor pops expected issues when PIM_load is seen.
module tb_pim_instr_issue;
  localparam int N = 38;
  localparam int DEPTH = 16;
  localparam int CW = $clog2(DEPTH) + 1;
  logic clk = 0, rst = 1, host_wr = 0, flush = 0, run = 0, PIM_done = 0;
  logic [N-1:0] host_instr = '0;
  logic [N-1:0] instr_out;
  logic PIM_load, busy, host_full, err_ovf;
  logic [CW-1:0] fifo_count;
  logic [15:0] issued_cnt;
  int checks = 0, errors = 0;

  pim_instr_issue #(.N(N), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .host_wr(host_wr), .host_instr(host_instr),
    .flush(flush), .run(run), .PIM_done(PIM_done), .instr_out(instr_out),
    .PIM_load(PIM_load), .busy(busy), .host_full(host_full),
    .fifo_count(fifo_count), .err_ovf(err_ovf), .issued_cnt(issued_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {logic [N-1:0] word; logic [15:0] cnt;} issue_t;
  logic [N-1:0] q[$];
  issue_t exp_q[$];
  logic m_exec = 0, m_load = 0, m_ovf = 0;
  logic [N-1:0] m_last = '0;
  logic [15:0] m_cnt = '0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, want, $time);
    end
  endtask

  // Reference model: the queue is the FIFO, m_exec means "waiting for done"
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      q.delete(); m_exec = 0; m_load = 0; m_ovf = 0; m_last = '0; m_cnt = '0;
    end else begin
      automatic logic iss = !m_exec && run && q.size() != 0 && !flush;
      automatic logic dn = m_exec && !m_load && PIM_done;
      if (flush) q.delete();
      else begin
        if (iss) begin
          m_last = q.pop_front();
          m_cnt = m_cnt + 16'd1;
          exp_q.push_back('{m_last, m_cnt});
        end
        if (host_wr) begin
          if (q.size() < DEPTH) q.push_back(host_instr);
          else m_ovf = 1;
        end
      end
      if (iss) m_exec = 1;
      else if (dn) m_exec = 0;
      m_load = iss;
    end
  end

  int cyc = 0, last_load = -100;
  always @(negedge clk) begin
    cyc++;
    chk("fifo_count", 64'(fifo_count), 64'(q.size()));
    chk("host_full", 64'(host_full), 64'(q.size() == DEPTH));
    chk("busy", 64'(busy), 64'(m_exec));
    chk("err_ovf", 64'(err_ovf), 64'(m_ovf));
    chk("PIM_load", 64'(PIM_load), 64'(m_load));
    chk("instr_out_hold", 64'(instr_out), 64'(m_last));
    if (PIM_load) begin
      chk("load_gap_ge3", 64'(cyc - last_load >= 3), 64'(1));
      last_load = cyc;
      if (exp_q.size() == 0) chk("unexpected_load", 64'(1), 64'(0));
      else begin
        automatic issue_t e = exp_q.pop_front();
        chk("issued_word", 64'(instr_out), 64'(e.word));
        chk("issued_cnt", 64'(issued_cnt), 64'(e.cnt));
      end
    end
  end

  function automatic logic [N-1:0] rnd_word();
    logic [63:0] t = {$urandom(), $urandom()};
    return t[N-1:0];
  endfunction

  task automatic step(input logic w, input logic [N-1:0] d, input logic r,
                      input logic f, input logic dn);
    @(negedge clk);
    host_wr = w; host_instr = d; run = r; flush = f; PIM_done = dn;
  endtask

  initial begin
    repeat (3) step(0, '0, 0, 0, 0);
    rst = 0;
    // single issue
    step(1, 38'h1_2345_6789, 1, 0, 0);
    repeat (4) step(0, '0, 1, 0, 0);
    step(0, '0, 1, 0, 1);
    step(0, '0, 0, 0, 0);
    chk("single_cnt", 64'(issued_cnt), 64'(1));
    chk("single_word", 64'(instr_out), 64'(38'h1_2345_6789));
    // ordered A,B,C with done held high: 3-cycle issue period
    step(1, 38'h0A, 0, 0, 0);
    step(1, 38'h0B, 0, 0, 0);
    step(1, 38'h0C, 0, 0, 0);
    repeat (12) step(0, '0, 1, 0, 1);
    // fill past full, then write in the pop cycle
    for (int i = 0; i < 17; i++) step(1, rnd_word(), 0, 0, 0);
    step(1, rnd_word(), 1, 0, 0);
    step(0, '0, 0, 0, 0);
    chk("full_pop_write_count", 64'(fifo_count), 64'(DEPTH));
    // run drop mid-EXEC, then flush with writes queued and instruction in flight
    step(0, '0, 0, 0, 1);
    step(0, '0, 1, 0, 0);
    step(0, '0, 0, 0, 0);
    repeat (3) step(0, '0, 0, 0, 1);
    step(1, rnd_word(), 1, 1, 0);
    step(1, rnd_word(), 1, 0, 0);
    step(0, '0, 0, 1, 0);
    repeat (3) step(0, '0, 0, 0, 1);
    // wrap: stream of writes and issues through the pointers
    for (int i = 0; i < 60; i++) step(i < 20, rnd_word(), 1, 0, 1);
    // randomized traffic
    for (int i = 0; i < 3000; i++)
      step($urandom % 2, rnd_word(), $urandom % 8 != 0, $urandom % 64 == 0, $urandom % 3 == 0);
    // async reset mid-EXEC with entries queued
    for (int i = 0; i < 5; i++) step(1, rnd_word(), 0, 0, 0);
    step(0, '0, 1, 0, 0);
    step(0, '0, 0, 0, 0);
    #2 rst = 1;
    #1;
    chk("rst_instr_out", 64'(instr_out), 64'(0));
    chk("rst_load", 64'(PIM_load), 64'(0));
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_count", 64'(fifo_count), 64'(0));
    chk("rst_full", 64'(host_full), 64'(0));
    chk("rst_ovf", 64'(err_ovf), 64'(0));
    chk("rst_issued", 64'(issued_cnt), 64'(0));
    step(0, '0, 1, 0, 0);
    rst = 0;
    step(1, rnd_word(), 1, 0, 0);
    repeat (6) step(0, '0, 1, 0, 1);
    step(0, '0, 0, 0, 0);
    chk("scoreboard_drained", 64'(exp_q.size()), 64'(0));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
